// File: rtl/freeplay_sequencer_if.sv
// Key/switch inputs and buzzer/LED outputs of the free-play sequencer.
// master drives the keys; slave is the sequencer.
interface freeplay_sequencer_if #(
    parameter int NOTE_KEYS = 7,
    parameter int LEN_KEYS  = 4,
    parameter int OCT_W     = 2
);
    logic                 en;
    logic                 oct_up;
    logic                 oct_down;
    logic [NOTE_KEYS-1:0] note_key;
    logic [LEN_KEYS-1:0]  length_key;
    logic [OCT_W-1:0]     octave;
    logic [NOTE_KEYS-1:0] led;
    logic                 buzzer;
    logic                 busy;
    logic                 overflow;

    modport master (
        output en, oct_up, oct_down, note_key, length_key,
        input  octave, led, buzzer, busy, overflow
    );

    modport slave (
        input  en, oct_up, oct_down, note_key, length_key,
        output octave, led, buzzer, busy, overflow
    );
endinterface

// File: rtl/freeplay_sequencer.sv
// Free-play sequencer: key hits -> event FIFO -> timed square-wave note with LED.
// Define FREEPLAY_HOLD_EN to keep a note sounding until its key is released.
module freeplay_sequencer #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int NOTE_KEYS  = 7,
    parameter int OCTAVES    = 3,
    parameter int LEN_KEYS   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int UNIT_MS    = 125,
    parameter int GAP_MS     = 20
) (
    input logic                 clk,
    input logic                 rst,
    freeplay_sequencer_if.slave bus
);
    localparam int OW       = (OCTAVES > 1) ? $clog2(OCTAVES) : 1;
    localparam int NW       = (NOTE_KEYS > 1) ? $clog2(NOTE_KEYS) : 1;
    localparam int LW       = (LEN_KEYS > 1) ? $clog2(LEN_KEYS) : 1;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int EW       = OW + NW + LW;
    localparam int UNIT_CYC = CLK_HZ / 1000 * UNIT_MS;
    localparam int GAP_CYC  = CLK_HZ / 1000 * GAP_MS;
    localparam int DUR_MAX  = UNIT_CYC * LEN_KEYS;
    localparam int CNT_MAX  = (DUR_MAX > GAP_CYC) ? DUR_MAX : GAP_CYC;
    localparam int DW       = $clog2(CNT_MAX + 1);
    localparam int TW       = $clog2(CLK_HZ / 524 + 1);
    // Half tone periods at the base octave, C..B (last entry pads the index range)
    localparam int HALF [8] = '{
        CLK_HZ / 524, CLK_HZ / 588, CLK_HZ / 660, CLK_HZ / 698,
        CLK_HZ / 784, CLK_HZ / 880, CLK_HZ / 988, CLK_HZ / 988
    };
    localparam logic [DW-1:0] GAP_LAST = DW'(GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_e;

    state_e               state_q, state_d;
    logic [NOTE_KEYS-1:0] note_cur_q, note_prev_q;
    logic [LEN_KEYS-1:0]  len_cur_q;
    logic                 up_cur_q, up_prev_q, dn_cur_q, dn_prev_q;
    logic [OW-1:0]        oct_q, oct_d;
    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [AW:0]          wp_q, wp_d, rp_q, rp_d;
    logic                 ovf_q, ovf_d;
    logic [EW-1:0]        ev_q, ev_d;
    logic [DW-1:0]        cnt_q, cnt_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic                 buzz_q, buzz_d;

    logic [NOTE_KEYS-1:0] note_edge;
    logic                 hit, up_e, dn_e, empty, full, push, pop;
    logic [NW-1:0]        hit_idx;
    logic [LW-1:0]        hit_len;
    logic [LW-1:0]        ev_len;
    logic [NW-1:0]        ev_note;
    logic [OW-1:0]        ev_oct;
    logic [DW-1:0]        dur_last;
    logic [TW-1:0]        tone_last;
    logic                 dur_done, play_done;

    assign ev_len  = ev_q[LW-1:0];
    assign ev_note = ev_q[LW +: NW];
    assign ev_oct  = ev_q[LW+NW +: OW];

    assign dur_last  = DW'((int'(ev_len) + 1) * UNIT_CYC - 1);
    assign tone_last = TW'((HALF[ev_note] >> ev_oct) - 1);
    assign dur_done  = (cnt_q == dur_last);
`ifdef FREEPLAY_HOLD_EN
    assign play_done = dur_done && !note_cur_q[ev_note];
`else
    assign play_done = dur_done;
`endif

    assign note_edge = note_cur_q & ~note_prev_q & {NOTE_KEYS{bus.en}};
    assign hit  = |note_edge;
    assign up_e = up_cur_q & ~up_prev_q & bus.en;
    assign dn_e = dn_cur_q & ~dn_prev_q & bus.en;

    always_comb begin
        hit_idx = '0;
        for (int i = NOTE_KEYS - 1; i >= 0; i--) begin
            if (note_edge[i]) hit_idx = NW'(i);
        end
        hit_len = '0;
        for (int i = 0; i < LEN_KEYS; i++) begin
            if (len_cur_q[i]) hit_len = LW'(i);
        end
    end

    always_comb begin
        oct_d = oct_q;
        if (up_e && !dn_e && oct_q != OW'(OCTAVES - 1)) begin
            oct_d = oct_q + OW'(1);
        end else if (dn_e && !up_e && oct_q != '0) begin
            oct_d = oct_q - OW'(1);
        end
    end

    assign empty = (wp_q == rp_q);
    assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign pop   = (state_q == LOAD);
    assign push  = hit && (!full || pop);

    always_comb begin
        wp_d  = push ? wp_q + (AW+1)'(1) : wp_q;
        rp_d  = pop ? rp_q + (AW+1)'(1) : rp_q;
        ovf_d = hit && full && !pop;
        if (!bus.en) begin
            wp_d = '0;
            rp_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        ev_d    = ev_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        buzz_d  = buzz_q;
        unique case (state_q)
            IDLE: if (!empty) state_d = LOAD;
            LOAD: begin
                ev_d    = mem_q[rp_q[AW-1:0]];
                cnt_d   = '0;
                tcnt_d  = '0;
                state_d = PLAY;
            end
            PLAY: begin
                if (tcnt_q == tone_last) begin
                    tcnt_d = '0;
                    buzz_d = ~buzz_q;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
                // Held past the minimum duration the counter parks on its last value
                if (play_done) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else if (!dur_done) begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = empty ? IDLE : LOAD;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (!bus.en) state_d = IDLE;
        if (state_d != PLAY) buzz_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            note_cur_q  <= '0;
            note_prev_q <= '0;
            len_cur_q   <= '0;
            up_cur_q    <= 1'b0;
            up_prev_q   <= 1'b0;
            dn_cur_q    <= 1'b0;
            dn_prev_q   <= 1'b0;
            oct_q       <= OW'(OCTAVES / 2);
            wp_q        <= '0;
            rp_q        <= '0;
            ovf_q       <= 1'b0;
            state_q     <= IDLE;
            ev_q        <= '0;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            buzz_q      <= 1'b0;
        end else begin
            note_cur_q  <= bus.note_key;
            note_prev_q <= note_cur_q;
            len_cur_q   <= bus.length_key;
            up_cur_q    <= bus.oct_up;
            up_prev_q   <= up_cur_q;
            dn_cur_q    <= bus.oct_down;
            dn_prev_q   <= dn_cur_q;
            oct_q       <= oct_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            ev_q        <= ev_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            buzz_q      <= buzz_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q[AW-1:0]] <= {oct_q, hit_idx, hit_len};
    end

    assign bus.octave   = oct_q;
    assign bus.led      = (state_q == PLAY) ? NOTE_KEYS'(1) << ev_note : '0;
    assign bus.buzzer   = buzz_q;
    assign bus.busy     = (state_q != IDLE) || !empty;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_freeplay_sequencer.sv
// Bench for freeplay_sequencer at 1 MHz with 1 ms units: played notes are
// captured off led/buzzer and compared against a note-level reference model.
module tb_freeplay_sequencer;
    localparam int UNIT = 1000;
    localparam int GAPC = 1000;
    localparam int FREQ [7] = '{262, 294, 330, 349, 392, 440, 494};

    typedef struct {
        int note; int dur; int rise; int fall; int start; int stop;
    } rec_t;
    typedef struct { int note; int len; int oct; } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_oct;
    int   cyc     = 0;
    int   ovf_cnt = 0;
    bit   in_play = 1'b0;
    rec_t cur;
    rec_t recs[$];
    ev_t  expq[$];

    always #5 clk = ~clk;

    freeplay_sequencer_if #(.NOTE_KEYS(7), .LEN_KEYS(4), .OCT_W(2)) bus ();

    freeplay_sequencer #(
        .CLK_HZ(1_000_000), .NOTE_KEYS(7), .OCTAVES(3), .LEN_KEYS(4),
        .FIFO_DEPTH(4), .UNIT_MS(1), .GAP_MS(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic int led_idx(input logic [6:0] v);
        led_idx = -1;
        if ($onehot(v)) for (int i = 0; i < 7; i++) if (v[i]) led_idx = i;
    endfunction

    function automatic int exp_half(input int note, input int oct);
        return (1_000_000 / (2 * FREQ[note])) >> oct;
    endfunction

    function automatic int exp_len(input int mask);
        return (mask == 0) ? 0 : $clog2(mask + 1) - 1;
    endfunction

    // Note capture: one record per contiguous run of non-zero led
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.overflow) ovf_cnt <= ovf_cnt + 1;
        if (bus.led != '0) begin
            if (!in_play) begin
                in_play   <= 1'b1;
                cur.note  <= led_idx(bus.led);
                cur.start <= cyc;
                cur.dur   <= 1;
                cur.rise  <= bus.buzzer ? 0 : -1;
                cur.fall  <= -1;
            end else begin
                cur.dur <= cur.dur + 1;
                if (bus.buzzer && cur.rise < 0) cur.rise <= cur.dur;
                if (!bus.buzzer && cur.rise >= 0 && cur.fall < 0) cur.fall <= cur.dur;
                if (cur.note < 0 || bus.led != 7'(1 << cur.note)) cur.note <= -1;
            end
        end else if (in_play) begin
            in_play <= 1'b0;
            recs.push_back('{note: cur.note, dur: cur.dur, rise: cur.rise,
                             fall: cur.fall, start: cur.start, stop: cyc});
        end
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [6:0] keys, input logic [3:0] lmask);
        bus.note_key   = keys;
        bus.length_key = lmask;
        tick(1);
        bus.note_key = '0;
        tick(1);
    endtask

    task automatic hit(input int note, input int lmask);
        if (bus.en) expq.push_back('{note: note, len: exp_len(lmask), oct: m_oct});
        press(7'(1 << note), 4'(lmask));
    endtask

    task automatic oct_op(input bit up, input bit dn);
        bus.oct_up   = up;
        bus.oct_down = dn;
        tick(1);
        bus.oct_up   = 1'b0;
        bus.oct_down = 1'b0;
        tick(1);
        if (bus.en && up && !dn && m_oct < 2) m_oct++;
        if (bus.en && dn && !up && m_oct > 0) m_oct--;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.note_key   = 7'($urandom);
            bus.length_key = 4'($urandom);
            bus.oct_up     = 1'($urandom);
            bus.oct_down   = 1'($urandom);
            tick(1);
        end
        n_tests += 5;
        if (bus.octave !== 2'd1) begin
            n_fail++; $display("FAIL reset_octave: got %0d want 1", bus.octave);
        end
        if (bus.led !== 7'd0) begin
            n_fail++; $display("FAIL reset_led: got %b want 0", bus.led);
        end
        if (bus.buzzer !== 1'b0) begin
            n_fail++; $display("FAIL reset_buzzer: got %b want 0", bus.buzzer);
        end
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        if (bus.overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_overflow: got %b want 0", bus.overflow);
        end
        bus.note_key = '0; bus.length_key = '0;
        bus.oct_up = 1'b0; bus.oct_down = 1'b0;
        tick(2);
        rst = 1'b0;
        m_oct = 1;
        tick(3);
    endtask

    task automatic test_single();
        int k = 0;
        int h, d;
        recs.delete();
        d = UNIT;
        h = exp_half(5, m_oct);
        bus.note_key = 7'b0100000;
        bus.length_key = '0;
        tick(1);
        k = 1;
        bus.note_key = '0;
        while (bus.led == '0 && k < 12) begin
            tick(1);
            k++;
        end
        n_tests += 2;
        if (k !== 4) begin
            n_fail++; $display("FAIL single_latency: got %0d want 4", k);
        end
        if (bus.led !== 7'b0100000) begin
            n_fail++; $display("FAIL single_led: got %b want 0100000", bus.led);
        end
        k = 0;
        while (bus.led != '0 && k < 3000) begin
            tick(1);
            k++;
        end
        tick(999);
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL single_gap_busy: got %b want 1", bus.busy);
        end
        tick(1);
        n_tests += 2;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL single_idle: got %b want 0", bus.busy);
        end
        if (recs.size() !== 1) begin
            n_fail++; $display("FAIL single_count: got %0d want 1", recs.size());
        end else begin
            n_tests++;
            if (recs[0].note !== 5 || recs[0].dur !== d ||
                recs[0].rise !== (h < d ? h : -1) || recs[0].fall !== (2*h < d ? 2*h : -1)) begin
                n_fail++;
                $display("FAIL single_note: got n%0d d%0d r%0d f%0d want n5 d%0d r%0d f%0d",
                         recs[0].note, recs[0].dur, recs[0].rise, recs[0].fall,
                         d, (h < d ? h : -1), (2*h < d ? 2*h : -1));
            end
        end
    endtask

    task automatic test_octave();
        int prev, h;
        bit ok;
        repeat (3) oct_op(1'b1, 1'b0);
        n_tests++;
        if (int'(bus.octave) !== m_oct) begin
            n_fail++; $display("FAIL oct_up_sat: got %0d want %0d", bus.octave, m_oct);
        end
        recs.delete();
        h = exp_half(5, m_oct);
        hit(5, 2);
        wait_idle(5000, ok);
        n_tests += 2;
        if (!ok) begin
            n_fail++; $display("FAIL oct_timeout: busy stuck");
        end
        if (recs.size() !== 1 || recs[0].dur !== 2*UNIT || recs[0].rise !== h ||
            recs[0].fall !== 2*h) begin
            n_fail++;
            $display("FAIL oct_tone: got cnt%0d d%0d r%0d f%0d want d%0d r%0d f%0d",
                     recs.size(), recs.size() ? recs[0].dur : -1,
                     recs.size() ? recs[0].rise : -1, recs.size() ? recs[0].fall : -1,
                     2*UNIT, h, 2*h);
        end
        expq.delete();
        prev = m_oct;
        oct_op(1'b1, 1'b1);
        n_tests++;
        if (int'(bus.octave) !== prev) begin
            n_fail++; $display("FAIL oct_both: got %0d want %0d", bus.octave, prev);
        end
        bus.en = 1'b0;
        oct_op(1'b0, 1'b1);
        bus.en = 1'b1;
        tick(2);
        n_tests++;
        if (int'(bus.octave) !== prev) begin
            n_fail++; $display("FAIL oct_disabled: got %0d want %0d", bus.octave, prev);
        end
        repeat (3) oct_op(1'b0, 1'b1);
        n_tests++;
        if (int'(bus.octave) !== m_oct) begin
            n_fail++; $display("FAIL oct_down_sat: got %0d want %0d", bus.octave, m_oct);
        end
    endtask

    task automatic test_same_cycle();
        bit ok;
        recs.delete();
        press(7'b0001001, 4'b0101);
        wait_idle(6000, ok);
        n_tests += 2;
        if (!ok) begin
            n_fail++; $display("FAIL same_timeout: busy stuck");
        end
        if (recs.size() !== 1 || recs[0].note !== 0 || recs[0].dur !== 3*UNIT) begin
            n_fail++;
            $display("FAIL same_cycle: got cnt%0d n%0d d%0d want cnt1 n0 d%0d",
                     recs.size(), recs.size() ? recs[0].note : -1,
                     recs.size() ? recs[0].dur : -1, 3*UNIT);
        end
    endtask

    task automatic test_queue();
        int o0, d, h;
        bit ok;
        repeat ($urandom_range(0, 2)) oct_op(1'b1, 1'b0);
        recs.delete();
        expq.delete();
        o0 = ovf_cnt;
        for (int n = 0; n < 5; n++) hit(n, $urandom_range(0, 3));
        press(7'b0100000, 4'b0000);
        tick(3);
        n_tests++;
        if (ovf_cnt - o0 !== 1) begin
            n_fail++; $display("FAIL queue_overflow: got %0d pulses want 1", ovf_cnt - o0);
        end
        wait_idle(17000, ok);
        n_tests += 2;
        if (!ok) begin
            n_fail++; $display("FAIL queue_timeout: busy stuck");
        end
        if (recs.size() !== 5) begin
            n_fail++; $display("FAIL queue_count: got %0d want 5", recs.size());
        end
        for (int i = 0; i < recs.size() && i < 5; i++) begin
            d = (expq[i].len + 1) * UNIT;
            h = exp_half(expq[i].note, expq[i].oct);
            n_tests++;
            if (recs[i].note !== expq[i].note || recs[i].dur !== d ||
                recs[i].rise !== (h < d ? h : -1) || recs[i].fall !== (2*h < d ? 2*h : -1)) begin
                n_fail++;
                $display("FAIL queue_note%0d: got n%0d d%0d r%0d want n%0d d%0d r%0d",
                         i, recs[i].note, recs[i].dur, recs[i].rise,
                         expq[i].note, d, (h < d ? h : -1));
            end
            if (i > 0) begin
                n_tests++;
                if (recs[i].start - recs[i-1].stop !== GAPC + 1) begin
                    n_fail++;
                    $display("FAIL queue_gap%0d: got %0d want %0d",
                             i, recs[i].start - recs[i-1].stop, GAPC + 1);
                end
            end
        end
        expq.delete();
    endtask

    task automatic test_en_drop();
        hit(0, 0);
        hit(1, 0);
        hit(2, 0);
        tick(100);
        n_tests++;
        if (bus.led !== 7'b0000001) begin
            n_fail++; $display("FAIL endrop_playing: got %b want 0000001", bus.led);
        end
        bus.en = 1'b0;
        tick(1);
        n_tests += 4;
        if (bus.led !== 7'd0) begin
            n_fail++; $display("FAIL endrop_led: got %b want 0", bus.led);
        end
        if (bus.buzzer !== 1'b0) begin
            n_fail++; $display("FAIL endrop_buzzer: got %b want 0", bus.buzzer);
        end
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL endrop_busy: got %b want 0", bus.busy);
        end
        if (int'(bus.octave) !== m_oct) begin
            n_fail++; $display("FAIL endrop_octave: got %0d want %0d", bus.octave, m_oct);
        end
        press(7'b1000000, 4'b0000);
        tick(2);
        bus.en = 1'b1;
        tick(20);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.led !== 7'd0) begin
            n_fail++; $display("FAIL endrop_reenable: got busy%b led%b want busy0 led0",
                               bus.busy, bus.led);
        end
        expq.delete();
        recs.delete();
    endtask

    task automatic test_hold();
        bit ok;
        recs.delete();
        bus.note_key = 7'b0000100;
        bus.length_key = '0;
        tick(5000);
        bus.note_key = '0;
        wait_idle(4000, ok);
        n_tests += 2;
        if (!ok) begin
            n_fail++; $display("FAIL hold_timeout: busy stuck");
        end
`ifdef FREEPLAY_HOLD_EN
        if (recs.size() !== 1 || recs[0].dur < 4990 || recs[0].dur > 5002) begin
            n_fail++; $display("FAIL hold_dur: got %0d want about 5000",
                               recs.size() ? recs[0].dur : -1);
        end
`else
        if (recs.size() !== 1 || recs[0].dur !== UNIT) begin
            n_fail++; $display("FAIL hold_dur: got %0d want %0d",
                               recs.size() ? recs[0].dur : -1, UNIT);
        end
`endif
    endtask

    task automatic test_reset_mid();
        repeat (2) oct_op(1'b0, 1'b1);
        press(7'b0010000, 4'b1000);
        tick(300);
        rst = 1'b1;
        tick(1);
        n_tests += 4;
        if (bus.octave !== 2'd1) begin
            n_fail++; $display("FAIL rstmid_octave: got %0d want 1", bus.octave);
        end
        if (bus.led !== 7'd0) begin
            n_fail++; $display("FAIL rstmid_led: got %b want 0", bus.led);
        end
        if (bus.buzzer !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_buzzer: got %b want 0", bus.buzzer);
        end
        if (bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_busy: got busy%b ovf%b want 0 0",
                               bus.busy, bus.overflow);
        end
        rst = 1'b0;
        m_oct = 1;
        tick(3);
        recs.delete();
        expq.delete();
    endtask

    task automatic test_random();
        int n, d, h, op;
        bit ok;
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 3)) begin
                op = $urandom_range(0, 2);
                oct_op(op != 1, op != 0);
            end
            n_tests++;
            if (int'(bus.octave) !== m_oct) begin
                n_fail++; $display("FAIL rand%0d_octave: got %0d want %0d", r, bus.octave, m_oct);
            end
            recs.delete();
            expq.delete();
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                hit($urandom_range(0, 6), $urandom_range(0, 3));
                tick($urandom_range(0, 2));
            end
            wait_idle(n * 3100 + 100, ok);
            n_tests += 2;
            if (!ok) begin
                n_fail++; $display("FAIL rand%0d_timeout: busy stuck", r);
            end
            if (recs.size() !== n) begin
                n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", r, recs.size(), n);
            end
            for (int i = 0; i < recs.size() && i < n; i++) begin
                d = (expq[i].len + 1) * UNIT;
                h = exp_half(expq[i].note, expq[i].oct);
                n_tests++;
                if (recs[i].note !== expq[i].note || recs[i].dur !== d ||
                    recs[i].rise !== (h < d ? h : -1) || recs[i].fall !== (2*h < d ? 2*h : -1)) begin
                    n_fail++;
                    $display("FAIL rand%0d_note%0d: got n%0d d%0d r%0d f%0d want n%0d d%0d r%0d f%0d",
                             r, i, recs[i].note, recs[i].dur, recs[i].rise, recs[i].fall,
                             expq[i].note, d, (h < d ? h : -1), (2*h < d ? 2*h : -1));
                end
                if (i > 0) begin
                    n_tests++;
                    if (recs[i].start - recs[i-1].stop !== GAPC + 1) begin
                        n_fail++;
                        $display("FAIL rand%0d_gap%0d: got %0d want %0d",
                                 r, i, recs[i].start - recs[i-1].stop, GAPC + 1);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b0;
        bus.oct_up = 1'b0;
        bus.oct_down = 1'b0;
        bus.note_key = '0;
        bus.length_key = '0;
        m_oct = 1;
        tick(2);
        test_reset();
        test_single();
        test_octave();
        test_same_cycle();
        test_queue();
        test_en_drop();
        test_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
